instruction_fetch: RTL and testbench

//   Fetch-side initiator for the 8-bit-address, 32-bit-word instruction ROM. Owns the program

---
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/instruction_fetch.sv | 98 +++++++++
 tb/tb_instruction_fetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: ROM port, downstream handshake, redirect/halt controls and status.
interface instruction_fetch_if #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned CNT_WIDTH   = 16
);
   logic [ADDR_WIDTH-1:0]  imem_address;
   logic [INSTR_WIDTH-1:0] imem_instruction;
   logic [INSTR_WIDTH-1:0] instr_out;
   logic [ADDR_WIDTH-1:0]  instr_pc;
   logic                   instr_valid;
   logic                   instr_ready;
   logic                   jump_valid;
   logic [ADDR_WIDTH-1:0]  jump_target;
   logic                   halt;
   logic                   halted;
   logic [CNT_WIDTH-1:0]   retired_count;

   // Fetch unit side
   modport master (
      output imem_address, instr_out, instr_pc, instr_valid, halted, retired_count,
      input  imem_instruction, instr_ready, jump_valid, jump_target, halt
   );

   // ROM / decode / control side
   modport slave (
      input  imem_address, instr_out, instr_pc, instr_valid, halted, retired_count,
      output imem_instruction, instr_ready, jump_valid, jump_target, halt
   );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, reads a zero-latency ROM and presents one registered word
// downstream over a valid/ready handshake. Supports jump redirect with flush and sticky halt.
module instruction_fetch #(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter int unsigned PC_STEP     = 4,
   parameter int unsigned RESET_PC    = 0,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input logic                 clock,
   input logic                 reset_n,
   instruction_fetch_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRun, StHalt} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
   logic [INSTR_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
   logic                   valid_q, valid_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                   adv;
   logic                   retire;

   assign adv    = !valid_q || bus.instr_ready;
   assign retire = valid_q && bus.instr_ready;

   // State, PC and output-slot registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         pc_q    <= ADDR_WIDTH'(RESET_PC);
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state: fetch/stall, jump redirect with flush, halt drain
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      unique case (state_q)
         StIdle: begin
            state_d = StRun;
         end
         StRun: begin
            if (bus.halt) begin
               // Halt wins over jump; keep presenting the pending word until it is taken.
               state_d = StHalt;
               valid_d = valid_q && !bus.instr_ready;
            end else if (bus.jump_valid) begin
               pc_d    = {bus.jump_target[ADDR_WIDTH-1:2], 2'b00};
               valid_d = 1'b0;
            end else if (adv) begin
               instr_d = bus.imem_instruction;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
            end
         end
         StHalt: begin
            valid_d = valid_q && !bus.instr_ready;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Retired counter: counts every handshake in any state, saturating at all-ones
   always_comb begin
      cnt_d = cnt_q;
      if (retire && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign bus.imem_address  = pc_q;
   assign bus.instr_out     = instr_q;
   assign bus.instr_pc      = ipc_q;
   assign bus.instr_valid   = valid_q;
   assign bus.halted        = (state_q == StHalt);
   assign bus.retired_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table plus hand-written halt, reset and
// saturation sequences; a scoreboard queue checks every retired word.
module tb_instruction_fetch;

   logic clock;
   logic reset_n;
   int   tests;
   int   fails;
   bit   sb_on;

   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] instr;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic        rdy;
      logic        jv;
      logic [7:0]  jt;
      logic        hl;
      logic [7:0]  addr;
      logic        vld;
      logic [7:0]  ipc;
      logic [15:0] cnt;
      logic        hlt;
   } vec_t;

   vec_t       vecs [14];
   logic       prev_vld;
   logic [7:0] prev_ipc;

   instruction_fetch_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(32), .CNT_WIDTH(16)) bus ();

   instruction_fetch #(
      .ADDR_WIDTH (8),
      .INSTR_WIDTH(32),
      .PC_STEP    (4),
      .RESET_PC   (0),
      .CNT_WIDTH  (16)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   function automatic logic [31:0] word(input logic [7:0] a);
      return 32'h1000_0000 + {24'h0, a};
   endfunction

   // Zero-latency ROM model
   assign bus.imem_instruction = word(bus.imem_address);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic rdy, input logic jv, input logic [7:0] jt,
                               input logic hl, input logic [7:0] addr, input logic vld,
                               input logic [7:0] ipc, input logic [15:0] cnt,
                               input logic hlt);
      vec_t v;
      v.rdy = rdy; v.jv = jv; v.jt = jt; v.hl = hl;
      v.addr = addr; v.vld = vld; v.ipc = ipc; v.cnt = cnt; v.hlt = hlt;
      return v;
   endfunction

   // Drive one cycle of inputs, then compare state after the edge
   task automatic apply(input vec_t v, input string tag);
      bus.instr_ready = v.rdy;
      bus.jump_valid  = v.jv;
      bus.jump_target = v.jt;
      bus.halt        = v.hl;
      if (prev_vld && v.rdy) sb_q.push_back({prev_ipc, word(prev_ipc)});
      @(posedge clock);
      #1;
      check({tag, " addr"}, {24'h0, bus.imem_address}, {24'h0, v.addr});
      check({tag, " valid"}, {31'h0, bus.instr_valid}, {31'h0, v.vld});
      check({tag, " count"}, {16'h0, bus.retired_count}, {16'h0, v.cnt});
      check({tag, " halted"}, {31'h0, bus.halted}, {31'h0, v.hlt});
      if (v.vld) begin
         check({tag, " ipc"}, {24'h0, bus.instr_pc}, {24'h0, v.ipc});
         check({tag, " instr"}, bus.instr_out, word(v.ipc));
      end
      prev_vld = v.vld;
      prev_ipc = v.ipc;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " addr"}, {24'h0, bus.imem_address}, 32'h0);
      check({tag, " instr"}, bus.instr_out, 32'h0);
      check({tag, " ipc"}, {24'h0, bus.instr_pc}, 32'h0);
      check({tag, " valid"}, {31'h0, bus.instr_valid}, 32'h0);
      check({tag, " halted"}, {31'h0, bus.halted}, 32'h0);
      check({tag, " count"}, {16'h0, bus.retired_count}, 32'h0);
   endtask

   // Scoreboard monitor: a handshake completes at the next rising edge
   always @(negedge clock) begin
      if (reset_n && sb_on && bus.instr_valid && bus.instr_ready) begin
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: retired pc %0h with nothing expected", bus.instr_pc);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            check("sb pc", {24'h0, bus.instr_pc}, {24'h0, e.pc});
            check("sb instr", bus.instr_out, e.instr);
         end
      end
   end

   initial begin
      tests = 0; fails = 0; sb_on = 1'b1;
      prev_vld = 1'b0; prev_ipc = 8'h0;
      reset_n = 1'b0;
      bus.instr_ready = 1'b0; bus.jump_valid = 1'b0; bus.jump_target = 8'h0; bus.halt = 1'b0;

      //            rdy jv jt     hl addr   vld ipc    cnt hlt
      vecs[0]  = mk(1, 0, 8'd0,   0, 8'd0,   0, 8'd0,   0, 0); // idle -> run
      vecs[1]  = mk(1, 0, 8'd0,   0, 8'd4,   1, 8'd0,   0, 0); // A
      vecs[2]  = mk(1, 0, 8'd0,   0, 8'd8,   1, 8'd4,   1, 0); // B
      vecs[3]  = mk(0, 0, 8'd0,   0, 8'd8,   1, 8'd4,   1, 0); // stall x3
      vecs[4]  = mk(0, 0, 8'd0,   0, 8'd8,   1, 8'd4,   1, 0);
      vecs[5]  = mk(0, 0, 8'd0,   0, 8'd8,   1, 8'd4,   1, 0);
      vecs[6]  = mk(1, 0, 8'd0,   0, 8'd12,  1, 8'd8,   2, 0); // C
      vecs[7]  = mk(0, 1, 8'd4,   0, 8'd4,   0, 8'd8,   2, 0); // jump, C flushed
      vecs[8]  = mk(1, 0, 8'd0,   0, 8'd8,   1, 8'd4,   2, 0); // B again
      vecs[9]  = mk(1, 0, 8'd0,   0, 8'd12,  1, 8'd8,   3, 0);
      vecs[10] = mk(1, 1, 8'h07,  0, 8'd4,   0, 8'd8,   4, 0); // low bits cleared, C retired
      vecs[11] = mk(1, 1, 8'd252, 0, 8'd252, 0, 8'd8,   4, 0);
      vecs[12] = mk(1, 0, 8'd0,   0, 8'd0,   1, 8'd252, 4, 0); // wrap
      vecs[13] = mk(1, 0, 8'd0,   0, 8'd4,   1, 8'd0,   5, 0);

      repeat (2) @(posedge clock);
      #1;
      check_reset_values("reset");
      reset_n = 1'b1;

      for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("v%0d", i));

      // Halt together with jump, pending word, ready low
      apply(mk(0, 1, 8'd40, 1, 8'd4, 1, 8'd0, 5, 1), "h0");
      apply(mk(0, 0, 8'd0,  0, 8'd4, 1, 8'd0, 5, 1), "h1");
      apply(mk(0, 1, 8'd8,  0, 8'd4, 1, 8'd0, 5, 1), "h2");
      apply(mk(1, 0, 8'd0,  0, 8'd4, 0, 8'd0, 6, 1), "h3");
      apply(mk(1, 1, 8'd16, 0, 8'd4, 0, 8'd0, 6, 1), "h4");
      apply(mk(1, 0, 8'd0,  1, 8'd4, 0, 8'd0, 6, 1), "h5");
      check("sb drained", sb_q.size(), 32'd0);

      // Asynchronous reset from HALT, mid-cycle
      #3 reset_n = 1'b0;
      #1 check_reset_values("async_reset_halt");

      // Long run: refetch from 0, pc wrap, counter saturation
      sb_on = 1'b0;
      bus.instr_ready = 1'b1; bus.jump_valid = 1'b0; bus.halt = 1'b0;
      #2 reset_n = 1'b1;
      for (int k = 1; k <= 65540; k++) begin
         @(posedge clock);
         #1;
         if (k == 1) check("run k1 valid", {31'h0, bus.instr_valid}, 32'h0);
         if (k == 2) begin
            check("refetch ipc", {24'h0, bus.instr_pc}, 32'h0);
            check("refetch instr", bus.instr_out, word(8'd0));
            check("refetch addr", {24'h0, bus.imem_address}, 32'd4);
         end
         if (k == 65536) check("count pre-sat", {16'h0, bus.retired_count}, 32'hFFFE);
         if (k == 65537) check("count sat", {16'h0, bus.retired_count}, 32'hFFFF);
      end
      check("count held", {16'h0, bus.retired_count}, 32'hFFFF);
      check("long ipc", {24'h0, bus.instr_pc}, 32'd8);
      check("long addr", {24'h0, bus.imem_address}, 32'd12);
      check("long instr", bus.instr_out, word(8'd8));
      check("long valid", {31'h0, bus.instr_valid}, 32'h1);

      // Asynchronous reset mid-stream discards the presented word
      #3 reset_n = 1'b0;
      #1 check_reset_values("async_reset_run");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
